sign_narrow_pipe: RTL and testbench



---
 rtl/sign_narrow_pkg.sv | 38 +++
 rtl/sign_narrow_sat.sv | 70 +++++++
 rtl/sign_narrow_pipe.sv | 145 ++++++++++++++
 tb/tb_sign_narrow_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sign_narrow_pkg.sv
// sign_narrow_pkg: shared types and width-derived constants for the
// sign_narrow_pipe width-narrowing converter.
//
// Optional build macro: SIGN_NARROW_WRAP_EN (consumed by sign_narrow_sat).
package sign_narrow_pkg;

    // Output sample width carried by the narrowed-sample record.
    localparam int SN_OUT_W = 4;

    // Skid buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // One narrowed sample together with its out-of-range flag.
    typedef struct packed {
        logic [SN_OUT_W-1:0] data;
        logic                sat;
    } narrow_t;

    // Largest two's complement value representable in w bits.
    function automatic longint signed_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest two's complement value representable in w bits.
    function automatic longint signed_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Largest unsigned value representable in w bits.
    function automatic longint unsigned_max(input int w);
        return (longint'(1) << w) - longint'(1);
    endfunction

endpackage

// File: rtl/sign_narrow_sat.sv
// sign_narrow_sat: combinational IN_W -> OUT_W narrowing of one sample,
// signed or unsigned, with an out-of-range flag.
//
// Build macro SIGN_NARROW_WRAP_EN: when defined the data is truncated to the
// low OUT_W bits instead of clamped; the flag still reports out-of-range.
module sign_narrow_sat
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic [OUT_W-1:0] nar_data,
    output logic             nar_sat
);

    // Range limits expressed at the input width so comparisons stay exact.
    localparam logic signed [IN_W-1:0] SMAX = IN_W'(signed_max(OUT_W));
    localparam logic signed [IN_W-1:0] SMIN = IN_W'(signed_min(OUT_W));
    localparam logic        [IN_W-1:0] UMAX = IN_W'(unsigned_max(OUT_W));

    // Clamp patterns: 0 followed by ones, 1 followed by zeros, all ones.
    localparam logic [OUT_W-1:0] DPOS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] DNEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] DUNS = {OUT_W{1'b1}};

    // Returns {sat, data} for a two's complement sample.
    function automatic logic [OUT_W:0] narrow_signed(input logic signed [IN_W-1:0] x);
        logic [OUT_W-1:0] d;
        logic             hi;
        logic             lo;
        hi = (x > SMAX);
        lo = (x < SMIN);
`ifdef SIGN_NARROW_WRAP_EN
        d = x[OUT_W-1:0];
`else
        if (hi)
            d = DPOS;
        else if (lo)
            d = DNEG;
        else
            d = x[OUT_W-1:0];
`endif
        return {hi | lo, d};
    endfunction

    // Returns {sat, data} for an unsigned sample.
    function automatic logic [OUT_W:0] narrow_unsigned(input logic [IN_W-1:0] x);
        logic [OUT_W-1:0] d;
        logic             hi;
        hi = (x > UMAX);
`ifdef SIGN_NARROW_WRAP_EN
        d = x[OUT_W-1:0];
`else
        d = hi ? DUNS : x[OUT_W-1:0];
`endif
        return {hi, d};
    endfunction

    // Select the interpretation of the incoming sample.
    always_comb begin
        {nar_sat, nar_data} = '0;
        if (in_signed)
            {nar_sat, nar_data} = narrow_signed($signed(in_data));
        else
            {nar_sat, nar_data} = narrow_unsigned(in_data);
    end

endmodule

// File: rtl/sign_narrow_pipe.sv
// sign_narrow_pipe: streaming IN_W -> OUT_W narrowing converter between
// valid/ready links. Samples are narrowed at acceptance, held in a 2-entry
// skid buffer (head + skid) and counted when out of range.
//
// Build macro SIGN_NARROW_WRAP_EN: truncate instead of clamp (see
// sign_narrow_sat); ports and flag/counter behaviour are unchanged.
module sign_narrow_pipe
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = SN_OUT_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [CNT_W-1:0] sat_count
);

    // The stored record width is fixed by the package; reject other shapes.
    if (IN_W <= OUT_W || OUT_W < 2 || OUT_W != SN_OUT_W) begin : g_param_check
        $error("sign_narrow_pipe: need IN_W > OUT_W >= 2 and OUT_W == SN_OUT_W");
    end

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             in_ready_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             vld_p1;
    logic             load_head_in;
    logic             load_skid_in;
    logic             load_head_skid;
    logic [OUT_W-1:0] nar_data_p0;
    logic             nar_sat_p0;
    narrow_t          nar_p0;
    narrow_t          head_p1;
    narrow_t          skid_p1;
    logic [CNT_W-1:0] cnt_q;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage p0: narrow the sample currently offered on the input link.
    sign_narrow_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .in_data   (in_data),
        .in_signed (in_signed),
        .nar_data  (nar_data_p0),
        .nar_sat   (nar_sat_p0)
    );

    assign nar_p0   = '{data: nar_data_p0, sat: nar_sat_p0};
    assign vld_p1   = (state_q != EMPTY);
    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = vld_p1 && out_ready;

    // Next occupancy and which register loads from where.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_head_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_head_in = 1'b1;
                end else if (in_xfer) begin
                    state_d      = TWO;
                    load_skid_in = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy register; in_ready follows the next state so it is a pure
    // register output and never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // Stage p1: head and skid sample registers, cleared by reset so no
    // stale sample survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_head_in)
                head_p1 <= nar_p0;
            else if (load_head_skid)
                head_p1 <= skid_p1;
            if (load_skid_in)
                skid_p1 <= nar_p0;
        end
    end

    // Count accepted out-of-range samples; clear wins, count sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr_count)
            cnt_q <= '0;
        else if (in_xfer && nar_sat_p0 && (cnt_q != CNT_MAX))
            cnt_q <= cnt_q + 1'b1;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = vld_p1;
    assign out_data  = head_p1.data;
    assign out_sat   = head_p1.sat;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_sign_narrow_pipe.sv
// Directed bench for sign_narrow_pipe (IN_W=8, OUT_W=4). A second instance
// with CNT_W=2 shares all inputs and exercises counter saturation.
module tb_sign_narrow_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_signed;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_sat;
    logic       clr_count;
    logic [15:0] sat_count;

    logic       in_ready_c;
    logic       out_valid_c;
    logic [3:0] out_data_c;
    logic       out_sat_c;
    logic [1:0] sat_count_c;

    int total = 0;
    int bad   = 0;
    logic [4:0] q[$];

    sign_narrow_pipe #(.IN_W(8), .OUT_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .clr_count(clr_count), .sat_count(sat_count)
    );

    sign_narrow_pipe #(.IN_W(8), .OUT_W(4), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .out_sat(out_sat_c),
        .clr_count(clr_count), .sat_count(sat_count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference narrowing: returns {sat, data} from integer range checks.
    function automatic logic [4:0] model(input logic [7:0] d, input logic s);
        int v;
        int lo;
        int hi;
        logic sat;
        logic [3:0] r;
        v  = s ? int'($signed(d)) : int'(d);
        lo = s ? -8 : 0;
        hi = s ? 7 : 15;
        sat = (v > hi) || (v < lo);
`ifdef SIGN_NARROW_WRAP_EN
        r = d[3:0];
`else
        if (v > hi)      r = hi[3:0];
        else if (v < lo) r = lo[3:0];
        else             r = d[3:0];
`endif
        return {sat, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the output offered this cycle, record the input
    // accepted this cycle, then advance to just after the rising edge.
    task automatic step(output bit acc);
        logic [4:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_data", 32'(out_data), 32'(e[3:0]));
                check("out_sat", 32'(out_sat), 32'(e[4]));
                check("out_data_c", 32'(out_data_c), 32'(e[3:0]));
            end
        end
        if (acc)
            q.push_back(model(in_data, in_signed));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        bit acc;
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        check("send_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Signed narrowing
        send(8'h7F, 1'b1);
        send(8'h80, 1'b1);
        send(8'hFD, 1'b1);
        send(8'h05, 1'b1);
        idle(3);
        check("signed_drained", 32'(q.size()), 32'd0);
        check("signed_sat_count", 32'(sat_count), 32'd2);

        // Unsigned narrowing
        send(8'h0F, 1'b0);
        send(8'h10, 1'b0);
        send(8'hFD, 1'b0);
        idle(3);
        check("unsigned_sat_count", 32'(sat_count), 32'd4);
        check("unsigned_sat_count_c", 32'(sat_count_c), 32'd3);

        // Backpressure
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'h03;
        in_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("bp_not_accepted", 32'(acc), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data_held", 32'(out_data), 32'h1);
        end
        out_ready = 1'b1;
        step(acc);
        check("bp_rel0_no_accept", 32'(acc), 32'd0);
        step(acc);
        check("bp_rel1_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        check("bp_rel2_valid", 32'(out_valid), 32'd1);
        step(acc);
        check("bp_all_out", 32'(q.size()), 32'd0);
        check("bp_idle_valid", 32'(out_valid), 32'd0);

        // Reset mid-operation with both entries occupied
        send(8'hFD, 1'b0);
        idle(2);
        check("pre_rst_sat_count", 32'(sat_count), 32'd5);
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sat_count", 32'(sat_count), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Counter saturation and clear priority
        for (int i = 0; i < 6; i++) send(8'h7F, 1'b1);
        idle(2);
        check("cnt_six", 32'(sat_count), 32'd6);
        check("cnt_c_held", 32'(sat_count_c), 32'd3);
        clr_count = 1'b1;
        send(8'h80, 1'b1);
        clr_count = 1'b0;
        check("clr_prio", 32'(sat_count), 32'd0);
        check("clr_prio_c", 32'(sat_count_c), 32'd0);
        send(8'h80, 1'b1);
        idle(3);
        check("cnt_after_clr", 32'(sat_count), 32'd1);
        check("final_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
